pipelined_adder: RTL

Parametrised, pipelined add/subtract unit: a WIDTH-bit operation is split into CHUNK-bit ripple slices, with one slice resolved per pipeline stage and the carry registered between stages. It sustains one operation per cycle under a valid/ready handshake with backpressure. It adds carry-in, subtract mode, carry-out and signed-overflow flags. It sits beside the RV32I execute path as the shared wide adder for address and multi-cycle arithmetic, where a single-cycle ripple chain is too slow.

---
 rtl/adder_pkg.sv | 29 ++
 rtl/adder_chunk.sv | 36 +++
 rtl/full_adder.sv | 15 +
 rtl/pipelined_adder.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types for the pipelined add/subtract unit.
//   add_op_e : operation select (OP_ADD / OP_SUB)
//   stage_t  : shape of one pipeline stage for the default 32/8 build
//              (valid, carry, sum, unprocessed a/b chunks)
//   eff_cin  : effective carry-in for the selected operation
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } add_op_e;

  localparam int STG_WIDTH = 32;
  localparam int STG_CHUNK = 8;

  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [STG_WIDTH-1:0] sum;
    logic [STG_WIDTH-1:0] a_rem;
    logic [STG_WIDTH-1:0] b_rem;
  } stage_t;

  // Subtraction is a + ~b + 1, so the caller's carry-in only matters for add.
  function automatic logic eff_cin(add_op_e op, logic cin);
    return (op == OP_SUB) ? 1'b1 : cin;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit ripple-carry slice built from full_adder cells.
//   a, b     : CHUNK-bit operands
//   cin      : carry into bit 0
//   s        : CHUNK-bit sum
//   cout     : carry out of the top bit
//   c_msb_in : carry into the top bit (pairs with cout for signed overflow)
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  // Unpacked so each carry is its own net rather than one self-feeding vector.
  logic c [0:CHUNK];

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder.
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract unit, one CHUNK-bit slice per stage.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   in_valid_i / in_ready_o  : operation handshake (in_ready_o = global enable)
//   op_i, a_i, b_i, cin_i    : operation, operands, carry-in (add only)
//   out_valid_o / out_ready_i: result handshake
//   sum_o, cout_o, ovf_o     : result, carry out of MSB, signed overflow
// Latency is STAGES = WIDTH/CHUNK cycles; one operation per cycle when unstalled.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  add_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int STAGES = WIDTH / CHUNK;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // The whole pipeline freezes only while a finished result is refused.
  assign en         = !(out_valid_o && !out_ready_i);
  assign in_ready_o = en;
  assign b_eff      = (op_i == OP_SUB) ? ~b_i : b_i;
  assign cin_eff    = eff_cin(op_i, cin_i);

  for (genvar k = 1; k <= STAGES; k++) begin : g_stg
    localparam int IN_W  = WIDTH - (k - 1) * CHUNK;
    localparam int SUM_W = k * CHUNK;

    logic             vld_in;
    logic             c_in;
    logic [IN_W-1:0]  a_in;
    logic [IN_W-1:0]  b_in;
    logic [CHUNK-1:0] s;
    logic             c_out;
    logic [SUM_W-1:0] sum_nxt;

    logic             vld_p;
    logic             carry_p;
    logic [SUM_W-1:0] sum_p;

    if (k == 1) begin : g_first
      assign vld_in  = in_valid_i;
      assign c_in    = cin_eff;
      assign a_in    = a_i;
      assign b_in    = b_eff;
      assign sum_nxt = s;
    end else begin : g_next
      assign vld_in  = g_stg[k-1].vld_p;
      assign c_in    = g_stg[k-1].carry_p;
      assign a_in    = g_stg[k-1].g_mid.a_p;
      assign b_in    = g_stg[k-1].g_mid.b_p;
      assign sum_nxt = {s, g_stg[k-1].sum_p};
    end

    // ---- stage k-1 -> stage k boundary: resolve chunk k-1, register carry ----
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_p   <= 1'b0;
        carry_p <= 1'b0;
        sum_p   <= '0;
      end else if (en) begin
        vld_p <= vld_in;
        if (vld_in) begin
          carry_p <= c_out;
          sum_p   <= sum_nxt;
        end
      end
    end

    if (k == STAGES) begin : g_last
      logic c_msb;
      logic ovf_p;

      adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (a_in[CHUNK-1:0]),
        .b        (b_in[CHUNK-1:0]),
        .cin      (c_in),
        .s        (s),
        .cout     (c_out),
        .c_msb_in (c_msb)
      );

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          ovf_p <= 1'b0;
        end else if (en && vld_in) begin
          ovf_p <= c_msb ^ c_out;
        end
      end
    end else begin : g_mid
      localparam int REM_W = IN_W - CHUNK;
      logic             c_msb_unused;
      logic [REM_W-1:0] a_p;
      logic [REM_W-1:0] b_p;

      adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (a_in[CHUNK-1:0]),
        .b        (b_in[CHUNK-1:0]),
        .cin      (c_in),
        .s        (s),
        .cout     (c_out),
        .c_msb_in (c_msb_unused)
      );

      // Only the chunks later stages still need travel forward.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          a_p <= '0;
          b_p <= '0;
        end else if (en && vld_in) begin
          a_p <= a_in[IN_W-1:CHUNK];
          b_p <= b_in[IN_W-1:CHUNK];
        end
      end
    end
  end

  assign out_valid_o = g_stg[STAGES].vld_p;
  assign sum_o       = g_stg[STAGES].sum_p;
  assign cout_o      = g_stg[STAGES].carry_p;
  assign ovf_o       = g_stg[STAGES].g_last.ovf_p;

endmodule
